// File: rtl/mlp_layer_sched.sv
// Layer sequencer for the 784-64-32-32-16-10 MLP: streams per-layer fan-in read addresses and PU strobes.
// Define SCHED_TIMEOUT_EN to build the WAIT_PU watchdog that aborts the run with err_o.
module mlp_layer_sched #(
  parameter int L1_IN       = 784,
  parameter int L1_OUT      = 64,
  parameter int L2_IN       = 64,
  parameter int L2_OUT      = 32,
  parameter int L3_IN       = 32,
  parameter int L3_OUT      = 32,
  parameter int L4_IN       = 32,
  parameter int L4_OUT      = 16,
  parameter int L5_IN       = 16,
  parameter int L5_OUT      = 10,
  parameter int ADDR_W      = 10,
  parameter int TADDR_W     = 6,
  parameter int READ_LAT    = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic               x_buf_en_o,
  output logic [ADDR_W-1:0]  x_buf_addr_o,
  output logic [4:0]         w_buf_en_o,
  output logic [ADDR_W-1:0]  w_buf_addr_o,
  output logic               temp_buf_en_o,
  output logic [TADDR_W-1:0] temp_buf_addr_o,
  output logic               temp_rd_bank_o,
  output logic               temp_wr_bank_o,
  output logic [2:0]         pu_layer_o,
  output logic [6:0]         pu_out_cnt_o,
  output logic               pu_valid_o,
  output logic               pu_first_o,
  output logic               pu_last_o,
  input  logic               pu_done_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_PU,
    S_DONE,
    S_ABORT
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          layer_q, layer_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                last_seen_q, last_seen_d;
  logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LAT-1:0] first_pipe_q, first_pipe_d;
  logic [READ_LAT-1:0] last_pipe_q, last_pipe_d;

  logic issue, idx_last, pu_accept, timeout;

  function automatic logic [ADDR_W-1:0] fan_in(input logic [2:0] k);
    case (k)
      3'd1:    fan_in = ADDR_W'(L1_IN);
      3'd2:    fan_in = ADDR_W'(L2_IN);
      3'd3:    fan_in = ADDR_W'(L3_IN);
      3'd4:    fan_in = ADDR_W'(L4_IN);
      3'd5:    fan_in = ADDR_W'(L5_IN);
      default: fan_in = '0;
    endcase
  endfunction

  function automatic logic [6:0] fan_out(input logic [2:0] k);
    case (k)
      3'd1:    fan_out = 7'(L1_OUT);
      3'd2:    fan_out = 7'(L2_OUT);
      3'd3:    fan_out = 7'(L3_OUT);
      3'd4:    fan_out = 7'(L4_OUT);
      3'd5:    fan_out = 7'(L5_OUT);
      default: fan_out = '0;
    endcase
  endfunction

  assign issue    = (state_q == S_ISSUE);
  assign idx_last = (idx_q == fan_in(layer_q) - ADDR_W'(1));
  // A done from the PU only counts once this layer's last operand has reached it.
  assign pu_accept = (state_q == S_WAIT_PU) && pu_done_i && last_seen_q;

`ifdef SCHED_TIMEOUT_EN
  logic [12:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = '0;
    if (state_q == S_WAIT_PU) wdog_d = wdog_q + 13'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  assign timeout = (state_q == S_WAIT_PU) && (wdog_q == 13'(TIMEOUT_CYC - 1));
  assign err_o   = (state_q == S_ABORT);
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  // Read-enable / first / last travel together so they line up with BRAM data.
  always_comb begin
    vld_pipe_d      = vld_pipe_q;
    first_pipe_d    = first_pipe_q;
    last_pipe_d     = last_pipe_q;
    vld_pipe_d[0]   = issue;
    first_pipe_d[0] = issue && (idx_q == '0);
    last_pipe_d[0]  = issue && idx_last;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_pipe_d[i]   = vld_pipe_q[i-1];
      first_pipe_d[i] = first_pipe_q[i-1];
      last_pipe_d[i]  = last_pipe_q[i-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    idx_d       = idx_q;
    last_seen_d = last_seen_q || pu_last_o;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_ISSUE;
          layer_d     = 3'd1;
          idx_d       = '0;
          last_seen_d = 1'b0;
        end
      end
      S_ISSUE: begin
        if (idx_last) begin
          state_d = S_WAIT_PU;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      S_WAIT_PU: begin
        if (pu_accept) begin
          last_seen_d = 1'b0;
          if (layer_q == 3'd5) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            layer_d = layer_q + 3'd1;
            idx_d   = '0;
          end
        end else if (timeout) begin
          state_d = S_ABORT;
        end
      end
      S_DONE, S_ABORT: begin
        state_d = S_IDLE;
        layer_d = 3'd0;
      end
      default: begin
        state_d = S_IDLE;
        layer_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      layer_q      <= '0;
      idx_q        <= '0;
      last_seen_q  <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      last_pipe_q  <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      idx_q        <= idx_d;
      last_seen_q  <= last_seen_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      last_pipe_q  <= last_pipe_d;
    end
  end

  assign busy_o = (state_q == S_ISSUE) || (state_q == S_WAIT_PU);
  assign done_o = (state_q == S_DONE);

  assign x_buf_en_o      = issue && (layer_q == 3'd1);
  assign x_buf_addr_o    = x_buf_en_o ? idx_q : '0;
  assign w_buf_en_o      = issue ? (5'd1 << (layer_q - 3'd1)) : 5'd0;
  assign w_buf_addr_o    = issue ? idx_q : '0;
  assign temp_buf_en_o   = issue && (layer_q != 3'd1);
  assign temp_buf_addr_o = temp_buf_en_o ? idx_q[TADDR_W-1:0] : '0;

  // Layer k writes bank (k-1)&1 and reads what layer k-1 wrote.
  assign temp_wr_bank_o = busy_o && !layer_q[0];
  assign temp_rd_bank_o = busy_o && (layer_q >= 3'd2) && layer_q[0];

  assign pu_layer_o   = busy_o ? layer_q : 3'd0;
  assign pu_out_cnt_o = busy_o ? fan_out(layer_q) : 7'd0;

  assign pu_valid_o = vld_pipe_q[READ_LAT-1];
  assign pu_first_o = first_pipe_q[READ_LAT-1];
  assign pu_last_o  = last_pipe_q[READ_LAT-1];

endmodule

// File: tb/tb_mlp_layer_sched.sv
// Self-checking bench for mlp_layer_sched: per-layer expectation table, PU responder and randomized handshakes.
// Exercises the SCHED_TIMEOUT_EN watchdog when that macro is defined.
module tb_mlp_layer_sched;
  localparam int ADDR_W  = 10;
  localparam int TADDR_W = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_i = 1'b0;
  logic               pu_done_i = 1'b0;
  logic               busy_o, done_o, err_o;
  logic               x_buf_en_o, temp_buf_en_o;
  logic [ADDR_W-1:0]  x_buf_addr_o, w_buf_addr_o;
  logic [4:0]         w_buf_en_o;
  logic [TADDR_W-1:0] temp_buf_addr_o;
  logic               temp_rd_bank_o, temp_wr_bank_o;
  logic [2:0]         pu_layer_o;
  logic [6:0]         pu_out_cnt_o;
  logic               pu_valid_o, pu_first_o, pu_last_o;

  always #5 clk = ~clk;

  mlp_layer_sched #(.TIMEOUT_CYC(100)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .err_o           (err_o),
    .x_buf_en_o      (x_buf_en_o),
    .x_buf_addr_o    (x_buf_addr_o),
    .w_buf_en_o      (w_buf_en_o),
    .w_buf_addr_o    (w_buf_addr_o),
    .temp_buf_en_o   (temp_buf_en_o),
    .temp_buf_addr_o (temp_buf_addr_o),
    .temp_rd_bank_o  (temp_rd_bank_o),
    .temp_wr_bank_o  (temp_wr_bank_o),
    .pu_layer_o      (pu_layer_o),
    .pu_out_cnt_o    (pu_out_cnt_o),
    .pu_valid_o      (pu_valid_o),
    .pu_first_o      (pu_first_o),
    .pu_last_o       (pu_last_o),
    .pu_done_i       (pu_done_i)
  );

  typedef struct {
    int fan_in;
    int fan_out;
    bit rd_bank;
    bit wr_bank;
  } layer_vec_t;

  layer_vec_t tbl [5];
  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int exp_done = 0;
  int exp_err = 0;

  always @(negedge clk) begin
    if (done_o) n_done++;
    if (err_o)  n_err++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] status();
    return 64'({busy_o, done_o, err_o, pu_layer_o, pu_out_cnt_o, temp_rd_bank_o,
                temp_wr_bank_o, x_buf_en_o, w_buf_en_o, temp_buf_en_o});
  endfunction

  // Expected status for layer k (0 = idle) while issuing reads or waiting on the PU.
  function automatic logic [63:0] exp_status(input int k, input bit issuing);
    if (k == 0) return 64'd0;
    return 64'({1'b1, 1'b0, 1'b0, 3'(k), 7'(tbl[k-1].fan_out), tbl[k-1].rd_bank,
                tbl[k-1].wr_bank, issuing && (k == 1), issuing ? 5'(1 << (k - 1)) : 5'd0,
                issuing && (k != 1)});
  endfunction

  function automatic logic [63:0] act_addr();
    return 64'({x_buf_en_o ? x_buf_addr_o : 10'd0, w_buf_addr_o,
                temp_buf_en_o ? temp_buf_addr_o : 6'd0});
  endfunction

  function automatic logic [63:0] strobe();
    return 64'({pu_valid_o, pu_valid_o & pu_first_o, pu_valid_o & pu_last_o});
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({status(), pu_valid_o, pu_first_o, pu_last_o, x_buf_addr_o, w_buf_addr_o,
                temp_buf_addr_o});
  endfunction

  // Starts a run from IDLE and follows it layer by layer; returns early for a mid-run
  // reset at (stop_k, stop_i) or, when pu_dly < 0, at WAIT_PU entry of layer 1.
  task automatic run(input int stop_k, input int stop_i, input int pu_dly, input bit noise);
    int dly;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      int fi;
      fi = tbl[k-1].fan_in;
      for (int i = 0; i < fi; i++) begin
        chk($sformatf("issue_status L%0d i%0d", k, i), status(), exp_status(k, 1'b1));
        chk($sformatf("issue_addr L%0d i%0d", k, i), act_addr(),
            64'({(k == 1) ? 10'(i) : 10'd0, 10'(i), (k != 1) ? 6'(i) : 6'd0}));
        chk($sformatf("issue_strobe L%0d i%0d", k, i), strobe(),
            (i == 0) ? 64'd0 : 64'({1'b1, i == 1, 1'b0}));
        if (k == stop_k && i == stop_i) begin
          rst_n     = 1'b0;
          start_i   = 1'b0;
          pu_done_i = 1'b0;
          #1;
          chk("async_reset_outputs", all_out(), 64'd0);
          return;
        end
        pu_done_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        start_i   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      pu_done_i = 1'b0;
      chk($sformatf("wait_entry L%0d", k), status(), exp_status(k, 1'b0));
      chk($sformatf("last_strobe L%0d", k), strobe(), 64'({1'b1, fi == 1, 1'b1}));
      if (pu_dly < 0) begin
        start_i = 1'b0;
        return;
      end
      dly = (pu_dly == 0) ? int'($urandom_range(1, 6)) : pu_dly;
      for (int j = 0; j < dly; j++) begin
        @(negedge clk);
        chk($sformatf("wait_status L%0d", k), status(), exp_status(k, 1'b0));
        chk($sformatf("wait_strobe L%0d", k), strobe(), 64'd0);
        start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      pu_done_i = 1'b1;
      @(negedge clk);
      pu_done_i = 1'b0;
      start_i   = 1'b0;
    end
    chk("done_cycle", 64'({done_o, busy_o, err_o, pu_layer_o, x_buf_en_o, w_buf_en_o, temp_buf_en_o}),
        64'({1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 1'b0}));
    exp_done++;
    start_i = 1'b1;  // coincides with done_o, must be ignored
    @(negedge clk);
    start_i = 1'b0;
    chk("idle_after_done", all_out(), 64'd0);
  endtask

  initial begin
    tbl[0] = '{784, 64, 1'b0, 1'b0};
    tbl[1] = '{64,  32, 1'b0, 1'b1};
    tbl[2] = '{32,  32, 1'b1, 1'b0};
    tbl[3] = '{32,  16, 1'b0, 1'b1};
    tbl[4] = '{16,  10, 1'b1, 1'b0};

    // Reset held with start asserted: everything stays quiet.
    rst_n   = 1'b0;
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_out(), 64'd0);
    start_i = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", all_out(), 64'd0);

    // Full run, PU answers 3 cycles after the last operand.
    run(0, 0, 3, 1'b0);

    // Randomized PU latency with spurious pu_done_i / start_i during the run.
    run(0, 0, 0, 1'b1);

    // Reset at layer 3, idx 10, then a clean restart from layer 1.
    run(3, 10, 0, 1'b0);
    @(negedge clk);
    chk("held_reset_outputs", all_out(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_midrun_reset", all_out(), 64'd0);
    run(0, 0, 0, 1'b1);

`ifdef SCHED_TIMEOUT_EN
    begin
      int n;
      n = -1;
      run(0, 0, -1, 1'b0);
      for (int j = 1; j <= 200 && n < 0; j++) begin
        @(negedge clk);
        if (err_o) begin
          n = j;
          chk("abort_busy_done", 64'({busy_o, done_o}), 64'd0);
        end
      end
      chk("timeout_latency", 64'(n), 64'd100);
      exp_err++;
      @(negedge clk);
      chk("idle_after_abort", all_out(), 64'd0);
    end
`endif

    repeat (2) @(negedge clk);
    chk("done_pulse_count", 64'(n_done), 64'(exp_done));
    chk("err_pulse_count", 64'(n_err), 64'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mlp_layer_sched.md
Name: mlp_layer_sched

Overview:
- Layer sequencer for the 5-layer MLP datapath (784-64-32-32-16-10).
- On start, walks layers 1..5 in order. For each layer it streams fan-in read addresses to x_buf (layer 1) or the ping-pong temp_buf (layers 2-5), plus the matching layer's w_buf.
- Emits operand-valid/first/last strobes aligned to BRAM read data, then waits for the PU to finish activation/writeback before moving to the next layer.
- Sits between the global controller's start/done and the buffer/PU datapath.

Parameters:
- L1_IN, L1_OUT: 784, 64: layer-1 fan-in / fan-out
- L2_IN, L2_OUT: 64, 32: layer-2 fan-in / fan-out
- L3_IN, L3_OUT: 32, 32: layer-3 fan-in / fan-out
- L4_IN, L4_OUT: 32, 16: layer-4 fan-in / fan-out
- L5_IN, L5_OUT: 16, 10: layer-5 fan-in / fan-out
- ADDR_W, 10: address width for x/w buffers; must be >= $clog2(L1_IN)
- TADDR_W, 6: temp_buf address width; must be >= $clog2(max of L2_IN..L5_IN)
- READ_LAT, 1: BRAM read latency in cycles (1..3)
- TIMEOUT_CYC, 4096: watchdog limit (only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- busy_o  out  1  high from the accepted start until done_o/err_o
- done_o  out  1  one-cycle pulse, all 5 layers complete
- err_o  out  1  one-cycle pulse on watchdog abort (0 without the optional feature)
- x_buf_en_o  out  1  x_buf read enable
- x_buf_addr_o  out  ADDR_W  x_buf read address
- w_buf_en_o  out  5  one-hot w_buf read enable; bit k-1 selects layer k
- w_buf_addr_o  out  ADDR_W  shared w_buf row address
- temp_buf_en_o  out  1  temp_buf read enable
- temp_buf_addr_o  out  TADDR_W  temp_buf read address
- temp_rd_bank_o  out  1  temp_buf bank being read
- temp_wr_bank_o  out  1  temp_buf bank the PU writes the layer outputs to
- pu_layer_o  out  3  current layer, 1..5; 0 in IDLE
- pu_out_cnt_o  out  7  fan-out of the current layer
- pu_valid_o  out  1  operand data valid at the PU this cycle
- pu_first_o  out  1  with pu_valid_o: first operand, PU clears accumulators
- pu_last_o  out  1  with pu_valid_o: last operand of the layer
- pu_done_i  in  1  PU finished activation and temp/y writeback for the layer

Behaviour:
- Reset: all outputs 0, state IDLE, layer 0, counters 0.
- FSM states and transitions:
  - IDLE: on start_i go to ISSUE, layer=1, idx=0, busy_o=1.
  - ISSUE: one read per cycle, idx = 0..Lk_IN-1.
    - Layer 1: x_buf_en_o=1, x_buf_addr_o=idx.
    - Layers 2-5: temp_buf_en_o=1, temp_buf_addr_o=idx[TADDR_W-1:0].
    - Always: w_buf_en_o bit k-1 set, w_buf_addr_o=idx.
    - After idx = Lk_IN-1, go to WAIT_PU on the next cycle; all enables drop.
  - WAIT_PU: wait for pu_done_i.
    - pu_done_i is accepted only once pu_last_o has been emitted for this layer; earlier assertions are ignored.
    - On accept: layer 5 goes to DONE; otherwise layer++, idx=0, back to ISSUE the next cycle.
  - DONE: done_o=1 for one cycle, busy_o drops in the same cycle, go to IDLE, pu_layer_o=0.
- Strobe alignment: pu_valid_o / pu_first_o / pu_last_o are the read-enable / (idx==0) / (idx==Lk_IN-1) signals delayed by exactly READ_LAT cycles through a shift pipeline.
- Ping-pong banks:
  - temp_wr_bank_o = (k-1)&1.
  - temp_rd_bank_o = k&1 for k>=2; 0 for layer 1.
  - Both are held constant for a whole layer.
- Enables are never asserted in IDLE, WAIT_PU or DONE.
- pu_out_cnt_o = Lk_OUT while busy, 0 otherwise.
- start_i while busy is ignored; no queueing.
- start_i in the same cycle as done_o is ignored; a new start is accepted from IDLE on the next cycle.
- Asynchronous reset mid-run returns immediately to the reset state. No done_o is produced; the pipeline is flushed.
- Per-layer cycle cost: Lk_IN (ISSUE) + PU response latency + 1 (WAIT_PU exit).

Optional Feature:
- Macro: SCHED_TIMEOUT_EN.
- Defined:
  - A 13-bit watchdog counts cycles in WAIT_PU and clears on state entry.
  - Reaching TIMEOUT_CYC without an accepted pu_done_i aborts: err_o pulses 1 cycle, busy_o drops, state goes to IDLE, no done_o.
- Undefined: no counter is built; err_o is tied 0; WAIT_PU waits indefinitely.

Test Plan:
- Reset check: rst_n=0 with start_i=1 -> all outputs 0. After release, start pulse -> busy_o=1 and x_buf_addr_o=0 the next cycle.
- Layer-1 stream, READ_LAT=1: start -> x_buf_en_o and w_buf_en_o=5'b00001 for exactly 784 cycles, addresses 0..783 contiguous. pu_first_o one cycle after addr 0; pu_last_o one cycle after addr 783.
- Full run, PU model returning pu_done_i 3 cycles after pu_last_o:
  - Layer sequence 1..5, fan-in counts 784/64/32/32/16.
  - temp_rd_bank_o 0,0,1,0,1 and temp_wr_bank_o 0,1,0,1,0.
  - Exactly one done_o pulse.
- Early/extra handshakes: pu_done_i held high during ISSUE -> ignored, layer not skipped. start_i during busy -> no restart, addresses undisturbed.
- Reset mid-run: rst_n low at layer 3, idx=10 -> outputs 0 immediately. A new start after release begins at layer 1, addr 0.
- With SCHED_TIMEOUT_EN, TIMEOUT_CYC=100, PU never responds -> err_o pulses 100 cycles after WAIT_PU entry, busy_o=0, no done_o.
